// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
// Holds the MDUOp encodings, the default latencies and the op-class
// predicates that both the MDU and the hazard unit use to classify MDUOp.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  // Multi-cycle op: mult, multu, div, divu.
  function automatic logic is_md(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Move-from op: mfhi, mflo.
  function automatic logic is_mf(input logic [3:0] op);
    return (op == MDU_MFHI) || (op == MDU_MFLO);
  endfunction

  // Move-to op: mthi, mtlo.
  function automatic logic is_mt(input logic [3:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational result datapath of the MDU.
// From the latched op and operands plus the current HI/LO it produces the
// HI/LO values to be written when the operation completes. Divide by zero
// keeps HI/LO; signed 0x80000000 / -1 yields LO=0x80000000, HI=0.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic signed [63:0] w_sprod;
  logic        [63:0] w_uprod;
  logic               w_b_zero;
  logic               w_ovf;
  logic        [31:0] w_b_sdiv;
  logic        [31:0] w_b_udiv;
  logic        [31:0] w_squot;
  logic        [31:0] w_srem;
  logic        [31:0] w_uquot;
  logic        [31:0] w_urem;

  assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
  assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

  assign w_b_zero = (i_b == 32'd0);
  assign w_ovf    = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

  // Dividing by 1 instead of -1 in the overflow case gives exactly the
  // required quotient 0x80000000 and remainder 0; substituting 1 for a zero
  // divisor keeps the dividers free of undefined results (those are discarded).
  assign w_b_sdiv = (w_b_zero || w_ovf) ? 32'd1 : i_b;
  assign w_b_udiv = w_b_zero ? 32'd1 : i_b;

  // Signed / and % truncate toward zero, remainder takes the dividend's sign.
  assign w_squot = $signed(i_a) / $signed(w_b_sdiv);
  assign w_srem  = $signed(i_a) % $signed(w_b_sdiv);
  assign w_uquot = i_a / w_b_udiv;
  assign w_urem  = i_a % w_b_udiv;

  // Select the completed result; anything that does not produce one holds HI/LO.
  always_comb begin
    o_hi = i_hi;
    o_lo = i_lo;
    unique case (i_op)
      MDU_MULT:  {o_hi, o_lo} = w_sprod;
      MDU_MULTU: {o_hi, o_lo} = w_uprod;
      MDU_DIV: begin
        if (!w_b_zero) begin
          o_hi = w_srem;
          o_lo = w_squot;
        end
      end
      MDU_DIVU: begin
        if (!w_b_zero) begin
          o_hi = w_urem;
          o_lo = w_uquot;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit with architectural HI/LO registers.
// Accepts mult/multu/div/divu on Start while idle, stays Busy for
// MULT_CYCLES/DIV_CYCLES and writes HI/LO on the edge where Busy falls.
// mthi/mtlo write HI/LO while idle; mfhi/mflo read them through MDUOut.
// Optional feature: define MDU_CANCEL_EN to add a Cancel input that aborts
// an in-flight operation without touching HI/LO.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] SA,
  input  logic [31:0] SB,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
`ifdef MDU_CANCEL_EN
  input  logic        Cancel,
`endif
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  mdu_op_e          r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic             w_cancel_in;
  logic             w_cancel;
  logic             w_accept;
  logic             w_done;
  logic [31:0]      w_hi_nxt;
  logic [31:0]      w_lo_nxt;

`ifdef MDU_CANCEL_EN
  assign w_cancel_in = Cancel;
`else
  assign w_cancel_in = 1'b0;
`endif

  assign Busy     = (r_cnt != '0);
  assign w_cancel = w_cancel_in && Busy;
  // A Start that coincides with Cancel is dropped even when idle.
  assign w_accept = Start && is_md(MDUOp) && !Busy && !w_cancel_in;
  assign w_done   = (r_cnt == CNT_W'(1)) && !w_cancel;

  mdu_calc u_calc (
    .i_op (r_op),
    .i_a  (r_a),
    .i_b  (r_b),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .o_hi (w_hi_nxt),
    .o_lo (w_lo_nxt)
  );

  // Latency counter plus latched op/operands for the operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state updates use <= so every register samples pre-edge values;
      // the operand latches are reset too so nothing stale survives a reset.
      r_cnt <= '0;
      r_op  <= MDU_NONE;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_cancel) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= (MDUOp == MDU_MULT || MDUOp == MDU_MULTU) ? CNT_W'(MULT_CYCLES)
                                                         : CNT_W'(DIV_CYCLES);
      r_op  <= mdu_op_e'(MDUOp);
      r_a   <= SA;
      r_b   <= SB;
    end else if (Busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // HI/LO: completion result on the falling-Busy edge, else mthi/mtlo when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end else if (!Busy && MDUOp == MDU_MTHI) begin
      r_hi <= SA;
    end else if (!Busy && MDUOp == MDU_MTLO) begin
      r_lo <= SA;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

  // mfhi/mflo read path to the E-stage result mux.
  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    MDUOut = 32'd0;
    if (MDUOp == MDU_MFHI)      MDUOut = r_hi;
    else if (MDUOp == MDU_MFLO) MDUOut = r_lo;
  end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu (default latencies 5/10).
// Inputs change and outputs are sampled on the falling clock edge.
// Cancel scenarios are exercised when built with MDU_CANCEL_EN.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] SA;
  logic [31:0] SB;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;
`ifdef MDU_CANCEL_EN
  logic        Cancel;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mdu dut (
    .clk    (clk),
    .reset_n(reset_n),
    .SA     (SA),
    .SB     (SB),
    .MDUOp  (MDUOp),
    .Start  (Start),
`ifdef MDU_CANCEL_EN
    .Cancel (Cancel),
`endif
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO),
    .MDUOut (MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op at the current falling edge, then count falling edges with Busy high.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    Start = 1'b1;
    MDUOp = op;
    SA    = a;
    SB    = b;
    @(negedge clk);
    Start = 1'b0;
    MDUOp = MDU_NONE;
    cycles = 0;
    while (Busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Apply a move-to op for one edge while idle.
  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    MDUOp = op;
    SA    = a;
    @(negedge clk);
    MDUOp = MDU_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    SA = '0; SB = '0; MDUOp = MDU_NONE; Start = 1'b0;
`ifdef MDU_CANCEL_EN
    Cancel = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_busy", Busy, 0);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    MDUOp = MDU_MFHI; #1;
    check("rst_mfhi", MDUOut, 0);
    MDUOp = MDU_NONE;
    @(negedge clk);

    // mult -2 * 3 = -6.
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_cycles", cyc, 5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // multu 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001.
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_cycles", cyc, 5);
    check("multu_hi", HI, 32'hFFFF_FFFE);
    check("multu_lo", LO, 32'h0000_0001);
    MDUOp = MDU_MFHI; #1;
    check("mfhi_out", MDUOut, 32'hFFFF_FFFE);
    MDUOp = MDU_MFLO; #1;
    check("mflo_out", MDUOut, 32'h0000_0001);
    MDUOp = MDU_MTHI; #1;
    check("mdout_other", MDUOut, 0);
    MDUOp = MDU_NONE;
    @(negedge clk);

    // div -7 / 2 = -3 rem -1.
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_cycles", cyc, 10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // divu 7 / 0: full latency, HI/LO unchanged.
    run_op(MDU_DIVU, 32'd7, 32'd0, cyc);
    check("divz_cycles", cyc, 10);
    check("divz_lo", LO, 32'hFFFF_FFFD);
    check("divz_hi", HI, 32'hFFFF_FFFF);

    // divu 100 / 7 = 14 rem 2.
    run_op(MDU_DIVU, 32'd100, 32'd7, cyc);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // Signed overflow 0x80000000 / -1.
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    // mult 2*3 with mthi, a second Start and operand churn while Busy.
    Start = 1'b1; MDUOp = MDU_MULT; SA = 32'd2; SB = 32'd3;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_MTHI; SA = 32'h1234_5678; SB = 32'd9;
    @(negedge clk);
    check("mthi_busy_hi", HI, 32'd0);
    Start = 1'b1; MDUOp = MDU_DIVU; SA = 32'd100; SB = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE; SA = 32'hDEAD_BEEF; SB = 32'h0BAD_F00D;
    cyc = 2;
    while (Busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    check("ign_cycles", cyc, 5);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);

    // mthi/mtlo while idle.
    move_to(MDU_MTHI, 32'h1234_5678);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'd6);
    move_to(MDU_MTLO, 32'hCAFE_F00D);
    check("mtlo_lo", LO, 32'hCAFE_F00D);
    check("mtlo_hi", HI, 32'h1234_5678);

    // Start with a non-multi-cycle op is ignored.
    Start = 1'b1; MDUOp = MDU_MFHI;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    check("start_mf_busy", Busy, 0);

    // Reset during a div: immediate clear, no late update.
    Start = 1'b1; MDUOp = MDU_DIVU; SA = 32'd100; SB = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", Busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_hi", HI, 0);
    check("mid_rst_lo", LO, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    check("post_rst_busy", Busy, 0);
    check("post_rst_hi", HI, 0);
    check("post_rst_lo", LO, 0);

`ifdef MDU_CANCEL_EN
    move_to(MDU_MTHI, 32'hAAAA_0000);
    move_to(MDU_MTLO, 32'h0000_BBBB);

    // Cancel at cycle 2 of a mult.
    Start = 1'b1; MDUOp = MDU_MULT; SA = 32'd2; SB = 32'd3;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    @(negedge clk);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    check("cancel_busy", Busy, 0);
    repeat (6) @(negedge clk);
    check("cancel_hi", HI, 32'hAAAA_0000);
    check("cancel_lo", LO, 32'h0000_BBBB);

    // Cancel on the completing edge.
    Start = 1'b1; MDUOp = MDU_MULT; SA = 32'd2; SB = 32'd3;
    @(negedge clk);
    Start = 1'b0; MDUOp = MDU_NONE;
    repeat (4) @(negedge clk);
    check("last_busy", Busy, 1);
    Cancel = 1'b1;
    @(negedge clk);
    Cancel = 1'b0;
    check("last_cancel_busy", Busy, 0);
    check("last_cancel_hi", HI, 32'hAAAA_0000);
    check("last_cancel_lo", LO, 32'h0000_BBBB);

    // Cancel coinciding with Start drops the Start.
    Start = 1'b1; Cancel = 1'b1; MDUOp = MDU_MULT; SA = 32'd2; SB = 32'd3;
    @(negedge clk);
    Start = 1'b0; Cancel = 1'b0; MDUOp = MDU_NONE;
    check("cancel_start_busy", Busy, 0);
    repeat (6) @(negedge clk);
    check("cancel_start_lo", LO, 32'h0000_BBBB);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
